ifid_skid_reg: RTL and testbench

Parametrised ready/valid pipeline register with a 2-entry skid buffer, used between any two stages of the 5-stage core (IF/ID first, later ID/EX, EX/MEM). It carries one instruction word plus a generic sideband data word (PC, decoded fields). Backpressure holds contents instead of dropping them, and a flush inserts a NOP bubble. Zero instruction words are replaced by the canonical NOP at capture, and an invalid output slot always presents NOP.

---
 rtl/ifid_skid_reg.sv | 143 ++++++++++++++
 tb/tb_ifid_skid_reg.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ifid_skid_reg.sv
// Ready/valid pipeline register with a 2-entry skid buffer (main + skid) and flush-to-bubble.
// Latency: 1 cycle from accept to output; 1 entry/cycle sustained while out_ready=1.
// Backpressure: entries are held, never dropped; in_ready is registered and deasserts only when both slots are full.
// Optional IFID_SKID_STATS_EN adds stall_cnt / flush_cnt statistics outputs.
module ifid_skid_reg #(
  parameter int                   INSTR_W   = 32,
  parameter int                   DATA_W    = 32,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = 32'h00000013
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [DATA_W-1:0]  data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [DATA_W-1:0]  data_out
`ifdef IFID_SKID_STATS_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [INSTR_W-1:0]   main_instr_q, main_instr_d;
  logic [DATA_W-1:0]    main_data_q, main_data_d;
  logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
  logic [DATA_W-1:0]    skid_data_q, skid_data_d;
  logic                 in_ready_q, in_ready_d;

  logic                 accept;
  logic                 take;
  logic [INSTR_W-1:0]   instr_san;

  // A zero instruction word is never a legal encoding here; store it as the bubble.
  assign instr_san = (instr_in == '0) ? NOP_INSTR : instr_in;
  assign accept    = in_valid & in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign take      = out_valid & out_ready;
  assign in_ready  = in_ready_q;
  // Invalid slot always shows the bubble, independent of what main happens to hold.
  assign instr_out = out_valid ? main_instr_q : NOP_INSTR;
  assign data_out  = out_valid ? main_data_q  : '0;

  // Next-state and slot updates; flush overrides every transition.
  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_data_d  = main_data_q;
    skid_instr_d = skid_instr_q;
    skid_data_d  = skid_data_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_instr_d = instr_san;
          main_data_d  = data_in;
          state_d      = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && take) begin
          main_instr_d = instr_san;
          main_data_d  = data_in;
        end else if (accept) begin
          skid_instr_d = instr_san;
          skid_data_d  = data_in;
          state_d      = ST_FULL;
        end else if (take) begin
          main_instr_d = NOP_INSTR;
          main_data_d  = '0;
          state_d      = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (take) begin
          main_instr_d = skid_instr_q;
          main_data_d  = skid_data_q;
          state_d      = ST_ONE;
        end
      end
      default: begin
        main_instr_d = NOP_INSTR;
        main_data_d  = '0;
        state_d      = ST_EMPTY;
      end
    endcase
    if (flush) begin
      main_instr_d = NOP_INSTR;
      main_data_d  = '0;
      state_d      = ST_EMPTY;
    end
    in_ready_d = (state_d != ST_FULL);
  end

  // State and storage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      main_instr_q <= NOP_INSTR;
      main_data_q  <= '0;
      skid_instr_q <= NOP_INSTR;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_data_q  <= main_data_d;
      skid_instr_q <= skid_instr_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

`ifdef IFID_SKID_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Free-running statistics; wrap naturally modulo 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_valid && !out_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush)                   flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Bench for ifid_skid_reg: directed vectors plus a random phase against a queue scoreboard.
// Latency: monitor samples on the falling edge, stimulus changes 1 time unit after the rising edge.
// Backpressure: scoreboard models in_ready/out_valid from its own occupancy.
module tb_ifid_skid_reg;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr_in = '0;
  logic [31:0] data_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] data_out;
`ifdef IFID_SKID_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  ifid_skid_reg dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr_in  (instr_in),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr_out (instr_out),
    .data_out  (data_out)
`ifdef IFID_SKID_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: entries pushed on accept, popped on take.
  logic [63:0] sb_q[$];
  logic        armed = 1'b0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;

  // Monitor: check outputs against the model, then apply the upcoming edge to the model.
  always @(negedge clk) begin
    logic        acc;
    logic [63:0] front;
    logic [31:0] exp_i;
    if (armed) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, sb_q.size() > 0});
      chk("in_ready",  {31'd0, in_ready},  {31'd0, sb_q.size() < 2});
      if (sb_q.size() > 0) begin
        front = sb_q[0];
        chk("instr_out", instr_out, front[63:32]);
        chk("data_out",  data_out,  front[31:0]);
      end else begin
        chk("idle_instr", instr_out, NOP);
        chk("idle_data",  data_out,  32'd0);
      end
`ifdef IFID_SKID_STATS_EN
      chk("stall_cnt", stall_cnt, m_stall);
      chk("flush_cnt", flush_cnt, m_flush);
`endif
    end
    if (reset) begin
      sb_q.delete();
      m_stall = '0;
      m_flush = '0;
      armed   = 1'b1;
    end else if (armed) begin
      acc = in_valid && (sb_q.size() < 2);
      if (sb_q.size() > 0 && !out_ready) m_stall = m_stall + 32'd1;
      if (flush) m_flush = m_flush + 32'd1;
      if (sb_q.size() > 0 && out_ready) void'(sb_q.pop_front());
      if (flush) sb_q.delete();
      else if (acc) begin
        exp_i = (instr_in == 32'd0) ? NOP : instr_in;
        sb_q.push_back({exp_i, data_in});
      end
    end
  end

  initial begin
    // Reset then idle.
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", instr_out, 32'h00000013);
    chk("rst_data",  data_out,  32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    cyc();

    // Stream four entries back to back.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      instr_in = 32'h00500093 + (i << 20);
      data_in  = 32'h100 + 4 * i;
      cyc();
      chk("stream_instr", instr_out, 32'h00500093 + (i << 20));
      chk("stream_data",  data_out,  32'h100 + 4 * i);
    end
    in_valid = 1'b0;
    cyc(); cyc();

    // Fill main and skid under backpressure, then drain.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr_in  = 32'h00A00113; data_in = 32'h300;
    cyc();
    instr_in  = 32'h00B00193; data_in = 32'h304;
    cyc();
    in_valid  = 1'b0;
    @(negedge clk);
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    chk("full_instr", instr_out, 32'h00A00113);
    cyc();
    out_ready = 1'b1;
    cyc();
    @(negedge clk);
    chk("drain1_instr", instr_out, 32'h00B00193);
    chk("drain1_ready", {31'd0, in_ready}, 32'd1);
    cyc(); cyc();

    // Zero instruction word becomes the bubble, sideband untouched.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr_in  = 32'd0; data_in = 32'h200;
    cyc();
    in_valid  = 1'b0;
    @(negedge clk);
    chk("zero_instr", instr_out, 32'h00000013);
    chk("zero_data",  data_out,  32'h200);
    chk("zero_valid", {31'd0, out_valid}, 32'd1);
    cyc();
    out_ready = 1'b1;
    cyc(); cyc();

    // Flush from FULL with a simultaneous offer.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr_in  = 32'h00C00213; data_in = 32'h400;
    cyc();
    instr_in  = 32'h00D00293; data_in = 32'h404;
    cyc();
    flush    = 1'b1;
    instr_in = 32'h00E00313; data_in = 32'h408;
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_instr", instr_out, 32'h00000013);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
`ifdef IFID_SKID_STATS_EN
    chk("flush_cnt1", flush_cnt, 32'd1);
`endif
    cyc();

    // Random traffic against the scoreboard.
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      instr_in  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      data_in   = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      reset     = ($urandom_range(0, 999) == 0);
      cyc();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc(); cyc();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
